// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: IO addresses, source bit
// positions, default vector layout and the priority-encoder result type.
package interrupt_controller_pkg;

   // Memory-mapped register addresses on the IO bus.
   localparam logic [15:0] ADDR_IF = 16'hFF0F;
   localparam logic [15:0] ADDR_IE = 16'hFFFF;

   // Default source count and vector of bit 0; vectors are 8 bytes apart.
   localparam int          DEF_NUM_INT  = 5;
   localparam logic [15:0] DEF_VEC_BASE = 16'h0040;
   localparam int          VEC_SHIFT    = 3;

   // Source bit positions inside IF/IE, lowest index has highest priority.
   typedef enum logic [2:0] {
      INT_VBLANK  = 3'd0,
      INT_LCDSTAT = 3'd1,
      INT_TIMER   = 3'd2,
      INT_SERIAL  = 3'd3,
      INT_JOYPAD  = 3'd4
   } int_idx_e;

   // Priority-encoder result: whether anything is requested and which bit won.
   typedef struct packed {
      logic       valid;
      logic [2:0] index;
   } int_sel_t;

   // Dispatch address for a given source index.
   function automatic logic [15:0] int_vector(input logic [15:0] base,
                                              input logic [2:0]  index);
      return base + (16'(index) << VEC_SHIFT);
   endfunction

endpackage

// File: rtl/interrupt_controller_priority_encoder.sv
// Combinational fixed-priority encoder: the lowest set request bit wins.
// Also used by the CPU debug path, so it carries no state of its own.
module int_priority_encoder
   import interrupt_controller_pkg::*;
#(
   parameter int NUM_INT = DEF_NUM_INT
) (
   input  logic [NUM_INT-1:0] req_i,
   output logic               valid_o,
   output logic [2:0]         index_o
);

   int_sel_t sel;

   // Scan from the top down so the last hit (lowest index) is the one kept.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first,
      // otherwise a path that does not assign it infers a latch.
      sel = '0;
      for (int i = NUM_INT - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            sel.valid = 1'b1;
            sel.index = 3'(i);
         end
      end
   end

   assign valid_o = sel.valid;
   assign index_o = sel.index;

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: latches peripheral requests into IF, masks them with
// IE, presents the winning vector to the CPU and handles the dispatch ack.
module interrupt_controller
   import interrupt_controller_pkg::*;
#(
   parameter int          NUM_INT  = DEF_NUM_INT,
   parameter logic [15:0] VEC_BASE = DEF_VEC_BASE
) (
   input  logic        I_CLOCK,
   input  logic        I_RESET,
   input  logic [15:0] I_ADDR,
   inout  wire  [7:0]  IO_DATA,
   input  logic        I_RE_L,
   input  logic        I_WE_L,
   input  logic        I_VBLANK_INT,
   input  logic        I_LCDSTAT_INT,
   input  logic        I_TIMER_INT,
   input  logic        I_SERIAL_INT,
   input  logic        I_JOYPAD_INT,
   input  logic        I_INT_ACK,
   output logic        O_INT_PENDING,
   output logic [15:0] O_INT_VECTOR,
   output logic [15:0] O_ACK_VECTOR,
   output logic        O_WAKE,
   output logic [7:0]  O_IF_DATA,
   output logic [7:0]  O_IE_DATA
);

   logic [NUM_INT-1:0] src_w;
   logic [NUM_INT-1:0] src_q;
   logic [NUM_INT-1:0] edge_w;
   logic [NUM_INT-1:0] if_q,  if_d;
   logic [7:0]         ie_q,  ie_d;
   logic [15:0]        ack_vec_q, ack_vec_d;
   logic [NUM_INT-1:0] masked_w;
   logic               win_valid_w;
   logic [2:0]         win_index_w;
   logic               wr_if_w, wr_ie_w, ack_take_w;
   logic               rd_en_w;
   logic [7:0]         rd_data_w;

   // Sources in IF bit order.
   assign src_w = NUM_INT'({I_JOYPAD_INT, I_SERIAL_INT, I_TIMER_INT,
                            I_LCDSTAT_INT, I_VBLANK_INT});

   // A rising level sets its flag exactly once, however long it is held.
   assign edge_w   = src_w & ~src_q;
   assign masked_w = if_q & ie_q[NUM_INT-1:0];

   int_priority_encoder #(.NUM_INT(NUM_INT)) u_prio (
      .req_i   (masked_w),
      .valid_o (win_valid_w),
      .index_o (win_index_w)
   );

   assign O_INT_PENDING = win_valid_w;
   assign O_WAKE        = win_valid_w;
   // With nothing pending the encoder index is 0, so this rests at VEC_BASE.
   assign O_INT_VECTOR  = int_vector(VEC_BASE, win_index_w);
   assign O_ACK_VECTOR  = ack_vec_q;
   assign O_IF_DATA     = {{(8-NUM_INT){1'b1}}, if_q};
   assign O_IE_DATA     = ie_q;

   assign wr_if_w    = !I_WE_L && (I_ADDR == ADDR_IF);
   assign wr_ie_w    = !I_WE_L && (I_ADDR == ADDR_IE);
   // An ack with nothing pending is dropped here; IME is the CPU's business.
   assign ack_take_w = I_INT_ACK && win_valid_w;

   // Next state for IF/IE/ack vector: bus write, then ack clear, then edges.
   always_comb begin
      if_d      = if_q;
      ie_d      = ie_q;
      ack_vec_d = ack_vec_q;
      if (wr_if_w) if_d = IO_DATA[NUM_INT-1:0];
      if (wr_ie_w) ie_d = IO_DATA;
      // NOTE: blocking assignments inside always_comb let later statements
      // override earlier ones, which is exactly how the precedence is built.
      if (ack_take_w) begin
         if_d[win_index_w] = 1'b0;
         ack_vec_d         = O_INT_VECTOR;
      end
      if_d = if_d | edge_w;
   end

   // Register state; an async reset returns everything to idle immediately.
   always_ff @(posedge I_CLOCK or posedge I_RESET) begin
      if (I_RESET) begin
         src_q     <= '0;
         if_q      <= '0;
         ie_q      <= '0;
         ack_vec_q <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop
         // samples pre-edge values regardless of statement order.
         src_q     <= src_w;
         if_q      <= if_d;
         ie_q      <= ie_d;
         ack_vec_q <= ack_vec_d;
      end
   end

   // Read mux; the bus is only driven during a read of one of our addresses.
   always_comb begin
      rd_en_w   = 1'b0;
      rd_data_w = 8'h00;
      if (!I_RE_L) begin
         if (I_ADDR == ADDR_IF) begin
            rd_en_w   = 1'b1;
            rd_data_w = O_IF_DATA;
         end else if (I_ADDR == ADDR_IE) begin
            rd_en_w   = 1'b1;
            rd_data_w = ie_q;
         end
      end
   end

   assign IO_DATA = rd_en_w ? rd_data_w : 8'hzz;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: a flag-level model is compared
// against the DUT every cycle, and directed scenarios pin literal values.
module tb_interrupt_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] addr = 16'h0000;
   logic        re_l = 1'b1;
   logic        we_l = 1'b1;
   logic        vbl = 1'b0, lcd = 1'b0, tim = 1'b0, ser = 1'b0, joy = 1'b0;
   logic        ack = 1'b0;
   logic        tb_oe = 1'b0;
   logic [7:0]  tb_wdata = 8'h00;
   wire  [7:0]  io_data;

   logic        pending, wake;
   logic [15:0] vector, ack_vector;
   logic [7:0]  if_data, ie_data;

   int checks = 0;
   int errors = 0;

   assign io_data = tb_oe ? tb_wdata : 8'hzz;

   interrupt_controller dut (
      .I_CLOCK       (clk),
      .I_RESET       (rst),
      .I_ADDR        (addr),
      .IO_DATA       (io_data),
      .I_RE_L        (re_l),
      .I_WE_L        (we_l),
      .I_VBLANK_INT  (vbl),
      .I_LCDSTAT_INT (lcd),
      .I_TIMER_INT   (tim),
      .I_SERIAL_INT  (ser),
      .I_JOYPAD_INT  (joy),
      .I_INT_ACK     (ack),
      .O_INT_PENDING (pending),
      .O_INT_VECTOR  (vector),
      .O_ACK_VECTOR  (ack_vector),
      .O_WAKE        (wake),
      .O_IF_DATA     (if_data),
      .O_IE_DATA     (ie_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] actual,
                        input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit [4:0]    m_if;
   bit [7:0]    m_ie;
   bit [4:0]    m_prev;
   bit [15:0]   m_ack;

   function automatic bit m_pending();
      return (m_if & m_ie[4:0]) != 5'd0;
   endfunction

   function automatic int m_winner();
      for (int i = 0; i < 5; i++)
         if (m_if[i] && m_ie[i]) return i;
      return 0;
   endfunction

   function automatic bit [15:0] m_vector();
      return 16'h0040 + 16'(8 * m_winner());
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_if = '0; m_ie = '0; m_prev = '0; m_ack = '0;
      end else begin
         bit [4:0] srcs, nxt;
         bit [7:0] nie;
         srcs = {joy, ser, tim, lcd, vbl};
         nxt  = m_if;
         nie  = m_ie;
         if (!we_l && addr == 16'hFF0F) nxt = io_data[4:0];
         if (!we_l && addr == 16'hFFFF) nie = io_data;
         if (ack && m_pending()) begin
            nxt[m_winner()] = 1'b0;
            m_ack = m_vector();
         end
         for (int i = 0; i < 5; i++)
            if (srcs[i] && !m_prev[i]) nxt[i] = 1'b1;
         m_prev = srcs;
         m_if   = nxt;
         m_ie   = nie;
      end
   end

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         check("pending",    {15'd0, pending}, {15'd0, m_pending()});
         check("wake",       {15'd0, wake},    {15'd0, m_pending()});
         check("vector",     vector,           m_vector());
         check("ack_vector", ack_vector,       m_ack);
         check("if_data",    {8'h00, if_data}, {8'h00, 3'b111, m_if});
         check("ie_data",    {8'h00, ie_data}, {8'h00, m_ie});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
      addr = a; tb_wdata = d; tb_oe = 1'b1; we_l = 1'b0;
      tick();
      we_l = 1'b1; tb_oe = 1'b0;
   endtask

   task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
      addr = a; re_l = 1'b0;
      #1;
      d = io_data;
      re_l = 1'b1;
   endtask

   task automatic pulse_ack();
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   logic [7:0] rd;

   initial begin
      // Reset state.
      #12;
      check("rst_pending", {15'd0, pending}, 16'h0000);
      check("rst_vector",  vector,           16'h0040);
      check("rst_ack",     ack_vector,       16'h0000);
      check("rst_if",      {8'h00, if_data}, 16'h00E0);
      @(posedge clk); #1;
      rst = 1'b0;
      tick();

      // Timer pulse with IE=04.
      bus_write(16'hFFFF, 8'h04);
      tim = 1'b1;
      tick();
      tim = 1'b0;
      check("t1_if",      {8'h00, if_data}, 16'h00E4);
      check("t1_pending", {15'd0, pending}, 16'h0001);
      check("t1_vector",  vector,           16'h0050);
      bus_read(16'hFF0F, rd);
      check("t1_rd_if",   {8'h00, rd},      16'h00E4);
      bus_read(16'hFFFF, rd);
      check("t1_rd_ie",   {8'h00, rd},      16'h0004);
      tick();

      // Three acks from IF=1F, IE=1F.
      bus_write(16'hFF0F, 8'h1F);
      bus_write(16'hFFFF, 8'h1F);
      pulse_ack();
      check("t2_ack0", ack_vector, 16'h0040);
      pulse_ack();
      check("t2_ack1", ack_vector, 16'h0048);
      pulse_ack();
      check("t2_ack2", ack_vector, 16'h0050);
      check("t2_if",   {8'h00, if_data}, 16'h00F8);
      check("t2_vec",  vector,           16'h0058);

      // Masked joypad flag, then enable IE.
      bus_write(16'hFFFF, 8'h00);
      bus_write(16'hFF0F, 8'h00);
      pulse_ack();                      // nothing pending: ignored
      check("t3_ack_ignored", ack_vector, 16'h0050);
      joy = 1'b1;
      tick();
      check("t3_if",      {8'h00, if_data}, 16'h00F0);
      check("t3_pending", {15'd0, pending}, 16'h0000);
      bus_write(16'hFFFF, 8'h10);
      check("t3_pend_on", {15'd0, pending}, 16'h0001);
      check("t3_vector",  vector,           16'h0060);
      joy = 1'b0;
      tick();

      // Held VBLANK sets its flag once; stays clear after ack.
      bus_write(16'hFF0F, 8'h00);
      bus_write(16'hFFFF, 8'h01);
      vbl = 1'b1;
      tick();
      check("t4_set", {8'h00, if_data}, 16'h00E1);
      pulse_ack();
      check("t4_ack", ack_vector, 16'h0040);
      for (int i = 0; i < 8; i++) tick();
      check("t4_held_clear", {8'h00, if_data}, 16'h00E0);
      vbl = 1'b0;
      tick();

      // Timer edge and ack of bit 2 in the same cycle.
      bus_write(16'hFFFF, 8'h04);
      bus_write(16'hFF0F, 8'h04);
      tim = 1'b1; ack = 1'b1;
      tick();
      tim = 1'b0; ack = 1'b0;
      check("t5_ack", ack_vector,       16'h0050);
      check("t5_if",  {8'h00, if_data}, 16'h00E4);

      // Bus write IF=00 with a serial edge in the same cycle.
      ser = 1'b1;
      bus_write(16'hFF0F, 8'h00);
      ser = 1'b0;
      check("t5_wr_edge", {8'h00, if_data}, 16'h00E8);
      tick();

      // Asynchronous reset mid-cycle.
      bus_write(16'hFF0F, 8'h1F);
      bus_write(16'hFFFF, 8'h1F);
      #2 rst = 1'b1;
      #1;
      check("t6_pending", {15'd0, pending}, 16'h0000);
      check("t6_wake",    {15'd0, wake},    16'h0000);
      check("t6_vector",  vector,           16'h0040);
      check("t6_ack",     ack_vector,       16'h0000);
      check("t6_if",      {8'h00, if_data}, 16'h00E0);
      check("t6_ie",      {8'h00, ie_data}, 16'h0000);
      @(posedge clk); #1;
      rst = 1'b0;
      tick();
      bus_read(16'hFF0F, rd);
      check("t6_rd_if", {8'h00, rd}, 16'h00E0);

      // Source already high when reset releases sets its flag on first clock.
      rst = 1'b1;
      lcd = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      check("t7_if", {8'h00, if_data}, 16'h00E2);
      lcd = 1'b0;
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Collects interrupt requests from the timer, LCD, serial and joypad blocks into the IF register (FF0F).
- Masks them with the IE register (FFFF) and presents the highest-priority pending request and its vector to the CPU.
- Handles the CPU acknowledge handshake.
- Sits between the peripheral blocks (timer_module's O_TIMER_INTERRUPT included) and the CPU core, on the shared memory-mapped IO bus.

Parameters:
- NUM_INT, 5, number of interrupt sources (bits 0..4 of IF/IE)
- VEC_BASE, 16'h0040, vector of bit 0; vector stride is 8 bytes

Ports:
- I_CLOCK  input  1  system clock (2^23 Hz)
- I_RESET  input  1  reset, asynchronous, active-high
- I_ADDR  input  16  bus address
- IO_DATA  inout  8  bus data, tristated
- I_RE_L  input  1  bus read enable, active-low
- I_WE_L  input  1  bus write enable, active-low
- I_VBLANK_INT  input  1  source bit 0
- I_LCDSTAT_INT  input  1  source bit 1
- I_TIMER_INT  input  1  source bit 2
- I_SERIAL_INT  input  1  source bit 3
- I_JOYPAD_INT  input  1  source bit 4
- I_INT_ACK  input  1  CPU dispatch acknowledge, single-cycle pulse
- O_INT_PENDING  output  1  |(IF & IE[4:0])
- O_INT_VECTOR  output  16  vector of highest-priority pending interrupt
- O_ACK_VECTOR  output  16  vector captured at the last accepted ack
- O_WAKE  output  1  HALT/STOP wake; equals O_INT_PENDING
- O_IF_DATA  output  8  debug: {3'b111, IF}
- O_IE_DATA  output  8  debug: IE

Behaviour:
- Reset (async, I_RESET high): IF=0, IE=0, source edge registers=0, O_ACK_VECTOR=0. Combinational outputs follow: O_INT_PENDING=0, O_WAKE=0, O_INT_VECTOR=VEC_BASE.
- Source capture:
  - Each source is rising-edge detected against its registered previous value.
  - A 1-cycle pulse and a held level both set the flag once.
  - Edge at clock n sets IF bit at edge n+1.
  - A source already high when reset releases sets its flag on the first clock.
- Bus writes:
  - IF write (I_WE_L low, I_ADDR==FF0F): IF <= IO_DATA[4:0].
  - IE write (FFFF): IE <= IO_DATA[7:0]; all 8 bits stored, only [4:0] used for masking.
- Bus reads:
  - FF0F drives {3'b111, IF}; FFFF drives IE.
  - Tristate is enabled only while I_RE_L is low and the address matches; the bus is released otherwise.
- Priority:
  - Lowest set bit of (IF & IE[4:0]) wins.
  - O_INT_VECTOR = VEC_BASE + 8*index, combinational. Values: 0040/0048/0050/0058/0060.
  - When nothing is pending, the vector is VEC_BASE.
- Ack:
  - On I_INT_ACK with O_INT_PENDING=1: clear the winning IF bit and capture O_INT_VECTOR into O_ACK_VECTOR, both at the same edge.
  - Ack with nothing pending is ignored; IF and O_ACK_VECTOR are unchanged.
  - IME (master enable) lives in the CPU, not here.
- Per-bit precedence in the same cycle: new source edge > ack clear > bus write to IF.
  - Edge and ack on the same bit: the bit stays 1, and the ack still captures the vector.
  - Bus write to IF and a source edge: written value, with the edging bit forced to 1.
- Latency: source edge -> O_INT_PENDING visible 1 cycle later (when the IE bit is set). An IE write takes effect on pending in the following cycle.
- Masked flags remain latched in IF. Enabling IE later raises pending immediately.

Decomposition:
- Address constants IF (16'hFF0F) and IE (16'hFFFF) go in the shared memdef.vh, next to DIV/TIMA/TMA/TAC.
- Bit index constants (INT_VBLANK..INT_JOYPAD) go in the same header.
- One sub-module: int_priority_encoder. Combinational, 5-bit masked request -> {valid, 3-bit index}. Reused by the CPU debug path.
- Storage reuses the existing register and tristate primitives.

Test Plan:
- Reset, IE<=FF write 8'h04, pulse I_TIMER_INT 1 cycle -> next cycle IF=04, O_INT_PENDING=1, O_INT_VECTOR=0050, FF0F reads E4.
- IF=1F preset, IE=1F, ack three times -> O_ACK_VECTOR 0040, 0048, 0050 in order; IF ends 18.
- IE=00, raise I_JOYPAD_INT -> IF=10 and pending=0; then write IE=10 -> pending=1 next cycle, vector 0060.
- Hold I_VBLANK_INT high 10 cycles, ack after the first set -> IF bit 0 set only once; it stays clear after ack despite the held level.
- Same-cycle I_TIMER_INT edge and ack of bit 2 (IE=04) -> O_ACK_VECTOR=0050, IF bit 2 remains 1. Same-cycle bus write IF=00 and serial edge -> IF=08.
- Assert I_RESET mid-operation with IF=1F, IE=1F -> all outputs return to reset values asynchronously; FF0F reads E0 after release.
